spi_flash_responder: RTL and testbench

- Synthesizable SPI flash device model: the responder end of the READ (0x03) transaction issued by the team's SPI flash controller.
- Samples SCK/CSbar/DI in the shared system clock domain. Decodes the 8-bit command and 24-bit address, then streams bytes from an internal byte array MSB-first on DO.
- Used as the flash stand-in for controller integration tests and FPGA bring-up. A host-side write port preloads the array.

---
 rtl/spi_flash_responder.sv | 142 ++++++++++++++
 tb/tb_spi_flash_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI flash stand-in: answers READ (0x03) transactions from a byte array.
// SCK/CSbar/DI are sampled directly in the system clock domain; DO streams MSB-first.
module spi_flash_responder #(
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              CSbar,
    input  logic              DI,
    output logic              DO,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              byte_sent,
    output logic              bad_cmd
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t      state, state_nx;
    logic        sck_q;
    logic [4:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  cmd_reg, cmd_nx;
    logic [23:0] addr_reg, addr_nx;
    logic [7:0]  tx_shift, tx_nx;
    logic        do_nx, byte_sent_nx, bad_cmd_nx;

    logic [7:0]  mem [2**ADDR_W];

    logic        rise, fall;
    logic [7:0]  cmd_shift;
    logic [23:0] addr_shift;
    logic [23:0] addr_inc;
    logic [7:0]  rd_byte;

    // A single-cycle SCK high phase must still be seen, so no synchronizer stages.
    assign rise       = SCK & ~sck_q & ~CSbar;
    assign fall       = ~SCK & sck_q & ~CSbar;
    assign cmd_shift  = (cmd_reg << 1) | {7'b0, DI};
    assign addr_shift = (addr_reg << 1) | {23'b0, DI};
    assign addr_inc   = {addr_reg[23:ADDR_W], addr_reg[ADDR_W-1:0] + ADDR_W'(1)};
    assign rd_byte    = mem[addr_reg[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (ld_en && CSbar)
            mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sck_q     <= 1'b0;
            bit_cnt   <= '0;
            cmd_reg   <= '0;
            addr_reg  <= '0;
            tx_shift  <= '0;
            DO        <= 1'b0;
            byte_sent <= 1'b0;
            bad_cmd   <= 1'b0;
        end else begin
            state     <= state_nx;
            sck_q     <= SCK;
            bit_cnt   <= bit_cnt_nx;
            cmd_reg   <= cmd_nx;
            addr_reg  <= addr_nx;
            tx_shift  <= tx_nx;
            DO        <= do_nx;
            byte_sent <= byte_sent_nx;
            bad_cmd   <= bad_cmd_nx;
        end
    end

    // Deselect overrides every state, even mid-byte.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        cmd_nx       = cmd_reg;
        addr_nx      = addr_reg;
        tx_nx        = tx_shift;
        do_nx        = DO;
        byte_sent_nx = 1'b0;
        bad_cmd_nx   = 1'b0;
        if (CSbar) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            do_nx      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx   = CMD;
                    bit_cnt_nx = '0;
                end
                CMD: if (rise) begin
                    cmd_nx     = cmd_shift;
                    bit_cnt_nx = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_nx = '0;
                        if (cmd_shift == READ_CMD) begin
                            state_nx = ADDR;
                        end else begin
                            bad_cmd_nx = 1'b1;
                            state_nx   = IGNORE;
                        end
                    end
                end
                ADDR: if (rise) begin
                    addr_nx    = addr_shift;
                    bit_cnt_nx = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt_nx = '0;
                        state_nx   = DATA;
                    end
                end
                DATA: begin
                    // DO moves only at the end of a fall cycle so it is stable while SCK is high.
                    if (fall) begin
                        if (bit_cnt == 5'd0) begin
                            tx_nx = rd_byte;
                            do_nx = rd_byte[7];
                        end else begin
                            tx_nx = tx_shift << 1;
                            do_nx = tx_shift[6];
                        end
                    end
                    if (rise) begin
                        bit_cnt_nx = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nx   = '0;
                            byte_sent_nx = 1'b1;
                            addr_nx      = addr_inc;
                        end
                    end
                end
                IGNORE: do_nx = 1'b0;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a bit-level SPI master plus an array model of
// the flash contents predicting every byte read back.
module tb_spi_flash_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              SCK     = 1'b0;
    logic              CSbar   = 1'b1;
    logic              DI      = 1'b0;
    logic              ld_en   = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_data = '0;
    logic              DO, byte_sent, bad_cmd;

    int checks   = 0;
    int failures = 0;
    int sent_cnt = 0;
    int bad_cnt  = 0;
    int do_hi    = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_W(ADDR_W), .READ_CMD(8'h03)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCK       (SCK),
        .CSbar     (CSbar),
        .DI        (DI),
        .DO        (DO),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .byte_sent (byte_sent),
        .bad_cmd   (bad_cmd)
    );

    // Pulse and DO-activity counters; tests measure deltas around each transaction.
    always @(negedge clk) begin
        if (byte_sent) sent_cnt++;
        if (bad_cmd)   bad_cnt++;
        if (DO)        do_hi++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a[ADDR_W-1:0];
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    // One SCK period: one clk cycle low (DI set up), one clk cycle high (DO sampled).
    task automatic xferBit(input logic di, output logic dout);
        @(negedge clk);
        SCK = 1'b0;
        DI  = di;
        @(negedge clk);
        dout = DO;
        SCK  = 1'b1;
    endtask

    task automatic sendBits(input logic [31:0] val, input int n);
        logic unused_bit;
        for (int i = n - 1; i >= 0; i--)
            xferBit(val[i], unused_bit);
    endtask

    task automatic recvByte(output logic [7:0] b);
        logic bit_o;
        for (int i = 7; i >= 0; i--) begin
            xferBit(1'($urandom), bit_o);
            b[i] = bit_o;
        end
    endtask

    task automatic beginTxn();
        @(negedge clk);
        SCK   = 1'b0;
        CSbar = 1'b0;
        @(negedge clk);
    endtask

    task automatic endTxn();
        @(negedge clk);
        SCK   = 1'b0;
        CSbar = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic [7:0] b;
        rx_q.delete();
        beginTxn();
        sendBits(32'(cmd), 8);
        sendBits(32'(addr), 24);
        repeat (nbytes) begin
            recvByte(b);
            rx_q.push_back(b);
        end
        endTxn();
    endtask

    task automatic expectRead(input string tag, input logic [23:0] addr, input int nbytes);
        int s0, b0, idx;
        s0 = sent_cnt;
        b0 = bad_cnt;
        applyStimulus(8'h03, addr, nbytes);
        for (int i = 0; i < nbytes; i++) begin
            idx = (int'(addr[ADDR_W-1:0]) + i) % DEPTH;
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(ref_mem[idx]));
        end
        checkOutput({tag, "_byte_sent"}, 32'(sent_cnt - s0), 32'(nbytes));
        checkOutput({tag, "_bad_cmd"}, 32'(bad_cnt - b0), 32'd0);
    endtask

    task automatic expectBadCmd(input string tag, input logic [7:0] cmd);
        int s0, b0, d0;
        s0 = sent_cnt;
        b0 = bad_cnt;
        d0 = do_hi;
        applyStimulus(cmd, 24'h000000, 1);
        checkOutput({tag, "_bad_cmd"}, 32'(bad_cnt - b0), 32'd1);
        checkOutput({tag, "_byte_sent"}, 32'(sent_cnt - s0), 32'd0);
        checkOutput({tag, "_do_high"}, 32'(do_hi - d0), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        logic        bit_o;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          s0, b0;

        #2 rst = 1'b0;
        #1;
        checkOutput("reset_do", 32'(DO), 32'd0);
        checkOutput("reset_byte_sent", 32'(byte_sent), 32'd0);
        checkOutput("reset_bad_cmd", 32'(bad_cmd), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < DEPTH; a++)
            preload(a, 8'($urandom));

        $display("[TB] integration read");
        preload(12'h010, 8'hA5);
        preload(12'h011, 8'hFF);
        expectRead("read_010", 24'h000010, 1);

        $display("[TB] continuous read with wrap");
        preload(12'h3FF, 8'h3C);
        preload(12'h000, 8'hC3);
        expectRead("wrap", 24'h0003FF, 2);

        $display("[TB] bad opcode");
        expectBadCmd("bad_0b", 8'h0B);
        expectRead("after_bad", 24'h000010, 1);

        $display("[TB] abort in address phase");
        beginTxn();
        sendBits(32'h03, 8);
        sendBits(32'h000, 12);
        @(negedge clk);
        SCK   = 1'b0;
        CSbar = 1'b1;
        @(negedge clk);
        checkOutput("abort_addr_do", 32'(DO), 32'd0);
        expectRead("after_abort", 24'h000010, 1);

        $display("[TB] abort mid-data");
        s0 = sent_cnt;
        beginTxn();
        sendBits(32'h03, 8);
        sendBits(32'h000011, 24);
        repeat (3) xferBit(1'b0, bit_o);
        checkOutput("abort_data_pre_do", 32'(bit_o), 32'd1);
        @(negedge clk);
        SCK   = 1'b0;
        CSbar = 1'b1;
        @(negedge clk);
        checkOutput("abort_data_do", 32'(DO), 32'd0);
        checkOutput("abort_data_byte_sent", 32'(sent_cnt - s0), 32'd0);
        expectRead("after_abort_data", 24'h000010, 1);

        $display("[TB] reset mid-data");
        s0 = sent_cnt;
        b0 = bad_cnt;
        beginTxn();
        sendBits(32'h03, 8);
        sendBits(32'h000011, 24);
        repeat (4) xferBit(1'b0, bit_o);
        checkOutput("rst_pre_do", 32'(bit_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_do", 32'(DO), 32'd0);
        checkOutput("rst_byte_sent", 32'(byte_sent), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        SCK   = 1'b0;
        CSbar = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_pulses", 32'((sent_cnt - s0) + (bad_cnt - b0)), 32'd0);
        expectRead("after_rst", 24'h000010, 2);

        $display("[TB] address high bits ignored");
        expectRead("high_bits", 24'hFFF010, 1);

        $display("[TB] randomized transactions");
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(4) == 0) begin
                do cmd = 8'($urandom); while (cmd == 8'h03);
                expectBadCmd($sformatf("rnd%0d_bad", r), cmd);
            end else begin
                repeat (2) preload(int'($urandom_range(DEPTH - 1)), 8'($urandom));
                addr = 24'($urandom);
                if ($urandom_range(3) == 0)
                    addr[ADDR_W-1:0] = ADDR_W'(DEPTH - 1 - int'($urandom_range(1)));
                expectRead($sformatf("rnd%0d", r), addr, int'($urandom_range(1, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
